// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: architectural PC, single-outstanding imem request
// handshake, and a PC-tagged instruction FIFO toward decode.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc_out
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         state;
    logic [31:0]    pc;
    logic [31:0]    req_pc;
    logic           drop;

    logic [31:0]    mem_pc   [FIFO_DEPTH];
    logic [31:0]    mem_data [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           hs;
    logic           flush;
    logic           push;
    logic           pop;
    logic [AW-1:0]  rd_next;
    logic [CW-1:0]  count_next;
    logic           head_from_push;
    logic [31:0]    redirect_pc;

    assign imem_req_valid = (state == REQ) && (count < CW'(FIFO_DEPTH));
    assign imem_req_addr  = pc & 32'hFFFF_FFFC;
    assign pc_out         = pc;
    assign inst_valid     = (count != '0);
    assign redirect_pc    = redirect_addr & 32'hFFFF_FFFC;

    always_comb begin
        hs         = imem_req_valid && imem_req_ready;
        flush      = redirect_valid && (state != BOOT);
        push       = (state == WAIT) && imem_rsp_valid && !drop && !flush;
        pop        = inst_valid && inst_ready && !flush;
        rd_next    = rd_ptr + AW'(pop);
        count_next = count + CW'(push) - CW'(pop);
        // The entry written this cycle becomes the head only when the FIFO drains to it.
        head_from_push = push && (rd_next == wr_ptr);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (flush) begin
                        pc <= redirect_pc;
                        if (hs) begin
                            req_pc <= pc;
                            drop   <= 1'b1;
                            state  <= WAIT;
                        end
                    end else if (hs) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc <= redirect_pc;
                        if (imem_rsp_valid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        drop  <= 1'b0;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc[wr_ptr]   <= req_pc;
            mem_data[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inst_data <= '0;
            inst_pc   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                if (head_from_push) begin
                    inst_data <= imem_rsp_data;
                    inst_pc   <= req_pc;
                end else begin
                    inst_data <= mem_data[rd_next];
                    inst_pc   <= mem_pc[rd_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: cycle vector table plus hand sequences for
// redirect, backpressure, PC wrap and mid-request reset.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RST_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_out;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;
    logic [31:0] w_pc_out;

    int total;
    int bad;
    int n;
    logic auto_rsp;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc_out(pc_out)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .CLK(CLK), .RST_n(RST_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .inst_ready(inst_ready), .pc_out(w_pc_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        ir;
        logic        erv;
        logic [31:0] era;
        logic        eiv;
        logic [31:0] eipc;
        logic [31:0] eid;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] rspd,
                                input logic ir, input logic erv, input logic [31:0] era,
                                input logic eiv, input logic [31:0] eipc, input logic [31:0] eid);
        vec_t v;
        v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.ir = ir;
        v.erv = erv; v.era = era; v.eiv = eiv; v.eipc = eipc; v.eid = eid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        logic hs;
        hs = imem_req_valid && imem_req_ready;
        @(posedge CLK);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hs ? (32'h1111_0000 + 32'(n)) : '0;
            if (hs) n++;
        end
    endtask

    task automatic do_reset();
        RST_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        auto_rsp       = 1'b0;
        n              = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        tbl[0]  = mk(1, 0, 32'h0,         1, 0, 32'h00, 0, 32'h00, 32'h0);
        tbl[1]  = mk(1, 0, 32'h0,         1, 1, 32'h00, 0, 32'h00, 32'h0);
        tbl[2]  = mk(1, 1, 32'h1111_0000, 1, 0, 32'h04, 0, 32'h00, 32'h0);
        tbl[3]  = mk(1, 0, 32'h0,         1, 1, 32'h04, 1, 32'h00, 32'h1111_0000);
        tbl[4]  = mk(1, 1, 32'h1111_0001, 1, 0, 32'h08, 0, 32'h00, 32'h1111_0000);
        tbl[5]  = mk(1, 0, 32'h0,         1, 1, 32'h08, 1, 32'h04, 32'h1111_0001);
        tbl[6]  = mk(1, 1, 32'h1111_0002, 1, 0, 32'h0C, 0, 32'h04, 32'h1111_0001);
        tbl[7]  = mk(1, 0, 32'h0,         0, 1, 32'h0C, 1, 32'h08, 32'h1111_0002);
        tbl[8]  = mk(1, 1, 32'h1111_0003, 0, 0, 32'h10, 1, 32'h08, 32'h1111_0002);
        tbl[9]  = mk(1, 0, 32'h0,         0, 0, 32'h10, 1, 32'h08, 32'h1111_0002);
        tbl[10] = mk(1, 0, 32'h0,         1, 0, 32'h10, 1, 32'h08, 32'h1111_0002);
        tbl[11] = mk(1, 0, 32'h0,         1, 1, 32'h10, 1, 32'h0C, 32'h1111_0003);
        tbl[12] = mk(1, 0, 32'h0,         1, 0, 32'h14, 0, 32'h0C, 32'h1111_0003);
        tbl[13] = mk(1, 1, 32'h1111_0004, 1, 0, 32'h14, 0, 32'h0C, 32'h1111_0003);
        tbl[14] = mk(0, 0, 32'h0,         0, 1, 32'h14, 1, 32'h10, 32'h1111_0004);
        tbl[15] = mk(1, 0, 32'h0,         0, 1, 32'h14, 1, 32'h10, 32'h1111_0004);
        tbl[16] = mk(1, 1, 32'h1111_0005, 1, 0, 32'h18, 1, 32'h10, 32'h1111_0004);
        tbl[17] = mk(0, 0, 32'h0,         1, 1, 32'h18, 1, 32'h14, 32'h1111_0005);
        tbl[18] = mk(0, 0, 32'h0,         0, 1, 32'h18, 0, 32'h14, 32'h1111_0005);

        // Vector table: in-order fetch, backpressure, delayed response, push+pop.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            check($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].erv));
            check($sformatf("v%0d req_addr", i),  imem_req_addr,       tbl[i].era);
            check($sformatf("v%0d pc_out", i),    pc_out,              tbl[i].era);
            check($sformatf("v%0d inst_valid", i), 32'(inst_valid),    32'(tbl[i].eiv));
            check($sformatf("v%0d inst_pc", i),   inst_pc,             tbl[i].eipc);
            check($sformatf("v%0d inst_data", i), inst_data,           tbl[i].eid);
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rspv;
            imem_rsp_data  = tbl[i].rspd;
            inst_ready     = tbl[i].ir;
            tick();
        end

        // FIFO full stalls fetch at pc 8, then resumes.
        do_reset();
        auto_rsp = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        repeat (8) tick();
        check("full req_valid", 32'(imem_req_valid), 32'd0);
        check("full pc_out", pc_out, 32'h8);
        check("full inst_pc", inst_pc, 32'h0);
        check("full inst_data", inst_data, 32'h1111_0000);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("resume req_valid", 32'(imem_req_valid), 32'd1);
        check("resume req_addr", imem_req_addr, 32'h8);
        check("resume inst_pc", inst_pc, 32'h4);
        check("resume inst_data", inst_data, 32'h1111_0001);
        tick();
        tick();
        check("refill req_valid", 32'(imem_req_valid), 32'd0);
        check("refill inst_pc", inst_pc, 32'h4);

        // Redirect during WAIT drops the in-flight response.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0043;
        tick();
        redirect_valid = 1'b0;
        check("rw pc_out", pc_out, 32'h40);
        check("rw req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check("rw drop inst_valid", 32'(inst_valid), 32'd0);
        check("rw drop inst_data", inst_data, 32'h0);
        check("rw next req_valid", 32'(imem_req_valid), 32'd1);
        check("rw next req_addr", imem_req_addr, 32'h40);
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0103;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_0000;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        check("rsp+redir inst_valid", 32'(inst_valid), 32'd0);
        check("rsp+redir req_valid", 32'(imem_req_valid), 32'd1);
        check("rsp+redir req_addr", imem_req_addr, 32'h100);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hABCD_0001;
        tick();
        imem_rsp_valid = 1'b0;
        check("after drop inst_valid", 32'(inst_valid), 32'd1);
        check("after drop inst_pc", inst_pc, 32'h100);
        check("after drop inst_data", inst_data, 32'hABCD_0001);

        // Redirect coinciding with response and pop flushes everything.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        tick();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_00AA;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        check("pre-flush inst_valid", 32'(inst_valid), 32'd1);
        check("pre-flush inst_pc", inst_pc, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_00BB;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        check("flush inst_valid", 32'(inst_valid), 32'd0);
        check("flush req_valid", 32'(imem_req_valid), 32'd1);
        check("flush req_addr", imem_req_addr, 32'h200);
        imem_req_ready = 1'b0;
        tick();
        check("flush+1 inst_valid", 32'(inst_valid), 32'd0);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("req redir req_valid", 32'(imem_req_valid), 32'd0);
        check("req redir pc_out", pc_out, 32'h300);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_5555;
        tick();
        imem_rsp_valid = 1'b0;
        check("req redir drop inst_valid", 32'(inst_valid), 32'd0);
        check("req redir next addr", imem_req_addr, 32'h300);
        check("req redir next valid", 32'(imem_req_valid), 32'd1);

        // PC wraps from 0xFFFF_FFFC to 0.
        do_reset();
        check("wrap reset addr", w_req_addr, 32'hFFFF_FFFC);
        check("wrap reset pc_out", w_pc_out, 32'hFFFF_FFFC);
        check("wrap reset req_valid", 32'(w_req_valid), 32'd0);
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        tick();
        check("wrap first addr", w_req_addr, 32'hFFFF_FFFC);
        check("wrap first valid", 32'(w_req_valid), 32'd1);
        tick();
        check("wrap pc_out", w_pc_out, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0077;
        tick();
        imem_rsp_valid = 1'b0;
        check("wrap second addr", w_req_addr, 32'h0);
        check("wrap second valid", 32'(w_req_valid), 32'd1);
        check("wrap inst_pc", w_inst_pc, 32'hFFFF_FFFC);
        check("wrap inst_data", w_inst_data, 32'h0000_0077);

        // Reset mid-request; stray responses and BOOT redirect are ignored.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        tick();
        tick();
        RST_n = 1'b0;
        #1;
        check("rst async req_valid", 32'(imem_req_valid), 32'd0);
        check("rst async pc_out", pc_out, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0099;
        tick();
        RST_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        check("rst stray inst_valid", 32'(inst_valid), 32'd0);
        check("rst stray inst_data", inst_data, 32'h0);
        check("rst req_valid", 32'(imem_req_valid), 32'd1);
        check("rst req_addr", imem_req_addr, 32'h0);
        check("boot redir pc_out", pc_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
